// File: rtl/mem_access.sv
// mem_access: pipeline MEM stage with req/ack data bus, lane alignment, misalign and bus-timeout detection
module mem_access #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic [2:0]  writeback_control_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  funct3_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic        is_csr_pype2,
    input  logic [11:0] csr_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] load_data_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic [2:0]  writeback_control_pype3,
    output logic        is_csr_pype3,
    output logic [11:0] csr_pype3,
    output logic        misalign_pype3,
    output logic        buserr_pype3
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_nxt;
    logic [31:0] cnt, lane, ext, wdata;
    logic [3:0] be;
    logic [1:0] off;
    logic mem_op, misalign, timeout, start, done, cap, mis_cap;

    assign mem_op = |MemRW_pype2;
    assign misalign = mem_op && ((dsize_pype2 == 2'b01 && ALU_co_pype[0]) ||
                                 (dsize_pype2 == 2'b10 && |ALU_co_pype[1:0]));
    assign timeout = state == REQ && !dmem_ack && TIMEOUT_CYCLES != 0 &&
                     cnt == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= (state == REQ && !done) ? cnt + 32'd1 : '0;
        end
    end

    always_comb begin
        state_nxt = state == IDLE ? (start ? REQ : IDLE) : (done ? IDLE : REQ);
    end

    always_comb begin
        start = state == IDLE && mem_op && !misalign;
        done = state == REQ && (dmem_ack || timeout);
        cap = state == IDLE ? !start : done;
        mis_cap = state == IDLE && misalign;
        mem_stall = !rst && (state == IDLE ? start : !done);
    end

    always_comb begin
        be = dsize_pype2 == 2'b00 ? 4'b0001 << ALU_co_pype[1:0] :
             dsize_pype2 == 2'b01 ? (ALU_co_pype[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = dsize_pype2 == 2'b00 ? {4{read_data2_pype2[7:0]}} :
                dsize_pype2 == 2'b01 ? {2{read_data2_pype2[15:0]}} : read_data2_pype2;
        lane = dmem_rdata >> {off, 3'b000};
        ext = funct3_pype2 == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
              funct3_pype2 == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
              funct3_pype2 == 3'b100 ? {24'd0, lane[7:0]} :
              funct3_pype2 == 3'b101 ? {16'd0, lane[15:0]} : lane;
    end

    // bus outputs are registered at request start and held until the access ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
            dmem_addr <= '0;
            dmem_be <= '0;
            dmem_wdata <= '0;
            off <= '0;
        end else if (start) begin
            dmem_req <= 1'b1;
            dmem_we <= !MemRW_pype2[1];
            dmem_addr <= {ALU_co_pype[31:2], 2'b00};
            dmem_be <= be;
            dmem_wdata <= wdata;
            off <= ALU_co_pype[1:0];
        end else if (done) begin
            dmem_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_co_pype3 <= '0;
            load_data_pype3 <= '0;
            PCp4_pype3 <= '0;
            WReg_pype3 <= '0;
            writeback_control_pype3 <= '0;
            is_csr_pype3 <= 1'b0;
            csr_pype3 <= '0;
            misalign_pype3 <= 1'b0;
            buserr_pype3 <= 1'b0;
        end else if (cap) begin
            ALU_co_pype3 <= ALU_co_pype;
            load_data_pype3 <= (state == REQ && dmem_ack && MemRW_pype2[1]) ? ext : '0;
            PCp4_pype3 <= PCp4_pype2;
            WReg_pype3 <= WReg_pype2;
            writeback_control_pype3 <= (mis_cap || timeout) ? 3'd0 : writeback_control_pype2;
            is_csr_pype3 <= mis_cap ? 1'b0 : is_csr_pype2;
            csr_pype3 <= csr_pype2;
            misalign_pype3 <= mis_cap;
            buserr_pype3 <= timeout;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized transaction-level check of mem_access with directed test-plan cases
module tb_mem_access;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2;
    logic [4:0] WReg_pype2;
    logic [2:0] writeback_control_pype2, funct3_pype2;
    logic [1:0] MemRW_pype2, dsize_pype2;
    logic is_csr_pype2;
    logic [11:0] csr_pype2;
    logic dmem_req, dmem_we, dmem_ack, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0] dmem_be;
    logic [31:0] ALU_co_pype3, load_data_pype3, PCp4_pype3;
    logic [4:0] WReg_pype3;
    logic [2:0] writeback_control_pype3;
    logic is_csr_pype3, misalign_pype3, buserr_pype3;
    logic [11:0] csr_pype3;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
        .PCp4_pype2(PCp4_pype2), .WReg_pype2(WReg_pype2),
        .writeback_control_pype2(writeback_control_pype2), .MemRW_pype2(MemRW_pype2),
        .funct3_pype2(funct3_pype2), .dsize_pype2(dsize_pype2), .is_csr_pype2(is_csr_pype2),
        .csr_pype2(csr_pype2), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .ALU_co_pype3(ALU_co_pype3), .load_data_pype3(load_data_pype3),
        .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
        .writeback_control_pype3(writeback_control_pype3), .is_csr_pype3(is_csr_pype3),
        .csr_pype3(csr_pype3), .misalign_pype3(misalign_pype3), .buserr_pype3(buserr_pype3)
    );

    typedef struct packed {
        logic [31:0] alu, ld, pc;
        logic [4:0]  wreg;
        logic [2:0]  wb;
        logic        is_csr;
        logic [11:0] csr;
        logic        mis, berr;
    } p3_t;

    typedef struct packed {
        logic [31:0] addr, rd2, pc;
        logic [4:0]  wreg;
        logic [2:0]  wb;
        logic [1:0]  mrw;
        logic [2:0]  f3;
        logic [1:0]  ds;
        logic        ic;
        logic [11:0] csr;
    } ins_t;

    p3_t act_p3, exp_p3;
    assign act_p3 = {ALU_co_pype3, load_data_pype3, PCp4_pype3, WReg_pype3, writeback_control_pype3,
                     is_csr_pype3, csr_pype3, misalign_pype3, buserr_pype3};

    int n_chk = 0, n_fail = 0, req_cnt = 0, stall_cnt = 0;
    bit chk_en = 0, fix_rd = 0;
    logic [31:0] fix_val = '0;
    logic exp_stall, exp_req, exp_we, seen_we;
    logic [31:0] exp_addr, exp_wdata, seen_addr, seen_wdata;
    logic [3:0] exp_be, seen_be;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_stall", mem_stall, exp_stall);
            check("dmem_req", dmem_req, exp_req);
            if (exp_req) begin
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_be", dmem_be, exp_be);
                check("dmem_wdata", dmem_wdata, exp_wdata);
                check("dmem_we", dmem_we, exp_we);
            end
            check("pype3", act_p3, exp_p3);
            if (dmem_req) begin
                req_cnt++;
                seen_addr = dmem_addr;
                seen_be = dmem_be;
                seen_wdata = dmem_wdata;
                seen_we = dmem_we;
            end
            if (mem_stall) stall_cnt++;
        end
    end

    function automatic ins_t mk(input logic [31:0] a, d, input logic [1:0] m, input logic [2:0] f,
                                input logic [1:0] s);
        mk.addr = a;
        mk.rd2 = d;
        mk.pc = $urandom;
        mk.wreg = 5'($urandom);
        mk.wb = 3'($urandom_range(1, 7));
        mk.mrw = m;
        mk.f3 = f;
        mk.ds = s;
        mk.ic = 1'($urandom);
        mk.csr = 12'($urandom);
    endfunction

    // one instruction held in EX/MEM until the stage releases it; w = wait cycles before ack
    task automatic run_instr(input ins_t i, input int w, input bit spur);
        p3_t r;
        bit mis, bus;
        int n, sz, lo;
        logic [31:0] sh;
        ALU_co_pype = i.addr;
        read_data2_pype2 = i.rd2;
        PCp4_pype2 = i.pc;
        WReg_pype2 = i.wreg;
        writeback_control_pype2 = i.wb;
        MemRW_pype2 = i.mrw;
        funct3_pype2 = i.f3;
        dsize_pype2 = i.ds;
        is_csr_pype2 = i.ic;
        csr_pype2 = i.csr;
        req_cnt = 0;
        stall_cnt = 0;
        sz = 1 << i.ds;
        lo = int'(i.addr % 4);
        mis = i.mrw != 0 && lo % sz != 0;
        bus = i.mrw != 0 && !mis;
        n = !bus ? 0 : (w < TO ? w + 1 : TO);
        exp_addr = i.addr - i.addr % 4;
        for (int b = 0; b < 4; b++) begin
            exp_be[b] = b >= lo && b < lo + sz;
            exp_wdata[8*b+:8] = i.rd2[8*(b%sz)+:8];
        end
        exp_we = i.mrw == 2'b01;
        r = '{i.addr, 32'd0, i.pc, i.wreg, i.wb, i.ic, i.csr, 1'b0, 1'b0};
        if (mis) begin
            r.wb = 0;
            r.is_csr = 0;
            r.mis = 1;
        end
        for (int k = 0; k <= n; k++) begin
            dmem_rdata = fix_rd ? fix_val : $urandom;
            dmem_ack = (bus && k >= 1 && k == w + 1) || (spur && k == 0);
            exp_stall = k == 0 ? bus : k < n;
            exp_req = k >= 1;
            if (k >= 1 && dmem_ack && i.mrw[1]) begin
                sh = dmem_rdata / (32'd1 << (8 * lo));
                case (i.f3)
                    3'b000: r.ld = 32'($signed(sh[7:0]));
                    3'b001: r.ld = 32'($signed(sh[15:0]));
                    3'b100: r.ld = 32'(sh[7:0]);
                    3'b101: r.ld = 32'(sh[15:0]);
                    default: r.ld = sh;
                endcase
            end
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        if (bus && w >= TO) begin
            r.wb = 0;
            r.berr = 1;
        end
        dmem_ack = 0;
        exp_p3 = r;
    endtask

    initial begin
        ins_t ins;
        {ALU_co_pype, read_data2_pype2, PCp4_pype2, WReg_pype2, writeback_control_pype2} = '0;
        {MemRW_pype2, funct3_pype2, dsize_pype2, is_csr_pype2, csr_pype2} = '0;
        dmem_ack = 0;
        dmem_rdata = '0;
        #12;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_be", dmem_be, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_pype3", act_p3, 0);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
        exp_p3 = '0;
        chk_en = 1;

        ins = mk(32'h40, 32'h0, 2'b00, 3'b000, 2'b10);
        ins.wreg = 5;
        run_instr(ins, 0, 0);
        check("add_alu", ALU_co_pype3, 32'h40);
        check("add_wreg", WReg_pype3, 5);
        check("add_stall_cycles", stall_cnt, 0);

        run_instr(mk(32'h1003, 32'h000000A5, 2'b01, 3'b000, 2'b00), 2, 0);
        check("sb_addr", seen_addr, 32'h1000);
        check("sb_be", seen_be, 4'b1000);
        check("sb_wdata", seen_wdata, 32'hA5A5A5A5);
        check("sb_we", seen_we, 1);
        check("sb_stall_cycles", stall_cnt, 3);
        check("sb_ld", load_data_pype3, 0);

        fix_rd = 1;
        fix_val = 32'h80011234;
        run_instr(mk(32'h2002, 32'h0, 2'b10, 3'b001, 2'b01), 0, 0);
        check("lh_data", load_data_pype3, 32'hFFFF8001);
        check("lh_stall_cycles", stall_cnt, 1);
        run_instr(mk(32'h2002, 32'h0, 2'b10, 3'b101, 2'b01), 0, 0);
        check("lhu_data", load_data_pype3, 32'h00008001);
        fix_rd = 0;

        run_instr(mk(32'h3001, 32'h0, 2'b10, 3'b010, 2'b10), 0, 0);
        check("lw_mis_flag", misalign_pype3, 1);
        check("lw_mis_wb", writeback_control_pype3, 0);
        check("lw_mis_req_cycles", req_cnt, 0);

        run_instr(mk(32'h5000, 32'h0, 2'b10, 3'b010, 2'b10), 100, 0);
        check("to_req_cycles", req_cnt, 4);
        check("to_buserr", buserr_pype3, 1);
        check("to_wb", writeback_control_pype3, 0);
        run_instr(mk(32'h44, 32'h0, 2'b00, 3'b000, 2'b10), 0, 0);
        check("to_clear_buserr", buserr_pype3, 0);

        run_instr(mk(32'h6000, 32'h0, 2'b10, 3'b010, 2'b10), TO - 1, 0);
        check("late_ack_req_cycles", req_cnt, 4);
        check("late_ack_no_buserr", buserr_pype3, 0);

        chk_en = 0;
        ins = mk(32'h4000, 32'h0, 2'b10, 3'b010, 2'b10);
        {ALU_co_pype, MemRW_pype2, funct3_pype2, dsize_pype2} = {ins.addr, ins.mrw, ins.f3, ins.ds};
        @(posedge clk);
        #1;
        check("rst_mid_pre_req", dmem_req, 1);
        #2 rst = 1;
        #1;
        check("rst_mid_req", dmem_req, 0);
        check("rst_mid_stall", mem_stall, 0);
        check("rst_mid_pype3", act_p3, 0);
        {ALU_co_pype, read_data2_pype2, PCp4_pype2, WReg_pype2, writeback_control_pype2} = '0;
        {MemRW_pype2, funct3_pype2, dsize_pype2, is_csr_pype2, csr_pype2} = '0;
        @(negedge clk) rst = 0;
        dmem_ack = 1;
        @(posedge clk);
        #1;
        dmem_ack = 0;
        exp_p3 = '0;
        chk_en = 1;
        run_instr(mk(32'h7004, 32'h0, 2'b10, 3'b010, 2'b10), 1, 1);
        check("post_rst_load_req_cycles", req_cnt, 2);
        check("post_rst_load_buserr", buserr_pype3, 0);

        for (int t = 0; t < 400; t++) begin
            logic [1:0] m, s;
            logic [31:0] a;
            logic [2:0] f;
            m = 2'($urandom_range(0, 2));
            s = 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            f = {1'b0, s};
            if (m == 2'b10 && s != 2'b10 && $urandom_range(0, 1) == 1) f[2] = 1'b1;
            run_instr(mk(a, $urandom, m, f, s), $urandom_range(0, 5), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline MEM stage. Sits directly downstream of the EX stage and consumes its EX/MEM pipeline register outputs.
- Performs data-memory loads and stores over a req/ack bus with variable wait states.
- Aligns, masks and extends data, detects misaligned accesses and bus timeouts.
- Drives the MEM/WB pipeline register and a stall to freeze upstream stages while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, number of REQ cycles without ack before the access is aborted as a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ALU_co_pype  in  32  EX result; byte address for loads and stores
- read_data2_pype2  in  32  store data, already low-aligned by EX
- PCp4_pype2  in  32  PC+4 of the instruction
- WReg_pype2  in  5  destination register
- writeback_control_pype2  in  3  WB control; 0 means no write
- MemRW_pype2  in  2  bit1 = load, bit0 = store; 00 means no memory access
- funct3_pype2  in  3  load/store width and signedness
- dsize_pype2  in  2  00 byte, 01 half, 10 word
- is_csr_pype2  in  1  CSR write flag
- csr_pype2  in  12  CSR address
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-positioned store data
- dmem_ack  in  1  transfer complete; rdata valid the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- ALU_co_pype3, load_data_pype3, PCp4_pype3  out  32 each  to WB
- WReg_pype3  out  5  to WB
- writeback_control_pype3  out  3  to WB
- is_csr_pype3  out  1  to WB
- csr_pype3  out  12  to WB
- misalign_pype3  out  1  misaligned-access flag
- buserr_pype3  out  1  bus-timeout flag

Behaviour:
- Reset (async, active-high):
  - state = IDLE, timeout counter = 0.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0.
  - All *_pype3 outputs = 0.
  - mem_stall = 0.
  - Asserting rst mid-access drops dmem_req immediately; a late ack is ignored.
- Misalignment (combinational): misalign = mem_op AND ((dsize 01 AND addr[0]) OR (dsize 10 AND addr[1:0] != 0)), where mem_op = (MemRW_pype2 != 0).
- State IDLE:
  - No mem_op: capture all pype2 fields into pype3 at the edge (1-cycle latency), load_data_pype3 = 0, mem_stall = 0.
  - misalign: no bus cycle, mem_stall = 0. Capture with writeback_control_pype3 = 0, is_csr_pype3 = 0, misalign_pype3 = 1.
  - Aligned mem_op: mem_stall = 1. At the edge, register dmem_addr/be/wdata/we, set dmem_req = 1, go to REQ.
- Byte lanes:
  - Byte: be = 0001 << addr[1:0], wdata = {4{rd2[7:0]}}.
  - Half: be = 0011 << {addr[1],1'b0}, wdata = {2{rd2[15:0]}}.
  - Word: be = 1111, wdata = rd2.
  - Loads use the same be; dmem_we = 0.
- State REQ:
  - dmem_req and all bus outputs stay stable until ack.
  - mem_stall = !dmem_ack.
  - On ack edge:
    - Capture pype3 fields; load_data_pype3 comes from rdata selected by addr[1:0].
    - Extension by funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero.
    - Stores give load_data_pype3 = 0.
    - Drop req, counter = 0, go to IDLE.
  - Minimum memory latency is 2 cycles (ack in the first REQ cycle).
- Timeout:
  - The counter increments each REQ cycle without ack.
  - When TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1 with no ack:
    - mem_stall = 0 that cycle.
    - At the edge: drop req, capture pype3 with writeback_control_pype3 = 0, buserr_pype3 = 1; go to IDLE.
  - Ack in that same cycle wins: normal completion, no error.
- misalign_pype3 and buserr_pype3 are cleared on the next normal capture.
- Every capture with no error writes both flags to 0.
- Stalled cycles do not update pype3: the WB register holds its value. WB tolerates the duplicate because EX/MEM is frozen.
- The address is held in dmem_addr throughout REQ, so upstream changes cannot corrupt it.

Test Plan:
- ADD result 0x00000040, MemRW = 00, WReg = 5 -> next edge: ALU_co_pype3 = 0x40, WReg_pype3 = 5; mem_stall never asserted.
- SB: addr 0x1003, rd2 = 0x000000A5, ack after 3 cycles -> dmem_addr = 0x1000, be = 1000, wdata = 0xA5A5A5A5, we = 1; mem_stall high for 3 cycles and low in the ack cycle.
- LH: addr 0x2002, rdata = 0x8001_1234, ack immediately -> load_data_pype3 = 0xFFFF8001. Repeat as LHU -> 0x00008001.
- LW at 0x3001 -> no dmem_req, misalign_pype3 = 1, writeback_control_pype3 = 0, 1-cycle latency.
- LW, ack never arrives, TIMEOUT_CYCLES = 4 -> req high exactly 4 cycles, then buserr_pype3 = 1, mem_stall released. Next ALU op clears buserr_pype3.
- rst pulsed during REQ -> dmem_req = 0 asynchronously, all pype3 outputs = 0; a following load completes normally.
